// File: rtl/blit_mem_write_pkg.sv
`default_nettype none
// blit_mem_write_pkg: state encoding and address-field constants shared by the blitter memory stages.
package blit_mem_write_pkg;

    localparam int BLIT_LINE_WORDS = 16;
    localparam int BLIT_LINE_BYTES = BLIT_LINE_WORDS * 4;

    // Byte address split: [ADDR_W-1:6] line, [5:2] word, [1:0] byte lane
    localparam int BLIT_LINE_LSB = 6;
    localparam int BLIT_WORD_MSB = 5;
    localparam int BLIT_WORD_LSB = 2;
    localparam int BLIT_BYTE_MSB = 1;

    typedef enum logic [2:0] {
        ST_CLEAN = 3'd0,
        ST_DIRTY = 3'd1,
        ST_REQ   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WAIT  = 3'd4
    } blit_state_e;

endpackage
`default_nettype wire

// File: rtl/blit_mem_write.sv
`default_nettype none
// blit_mem_write: merges pixels into a 64-byte write-combining line and
// writes it to SDRAM as a 16-beat masked burst on line change or flush.
module blit_mem_write
    import blit_mem_write_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p4_write,
    input  logic [31:0]       p4_dst_addr,
    input  logic [7:0]        p4_src_data,
    input  logic              flush_req,
    output logic              idle,
    output logic              stall,
    output logic              blitw_sdram_req,
    output logic [ADDR_W-1:0] blitw_sdram_addr,
    input  logic              blitw_sdram_ack,
    input  logic              blitw_sdram_wready,
    output logic [31:0]       blitw_sdram_wdata,
    output logic [3:0]        blitw_sdram_wmask,
    input  logic              blitw_sdram_complete
);

    localparam int LINE_W = ADDR_W - BLIT_LINE_LSB;

    blit_state_e             state_q;
    logic [LINE_W-1:0]       line_addr_q;
    logic [31:0]             data_q [LINE_WORDS];
    logic [LINE_WORDS*4-1:0] mask_q;
    logic [3:0]              rptr_q;
    logic                    req_q;

    logic [LINE_W-1:0]       pix_line;
    logic [3:0]              pix_word;
    logic [1:0]              pix_lane;
    logic [5:0]              pix_byte;
    logic                    line_hit;
    logic                    busy;
    logic                    accept;
    logic                    unused_addr_hi;

    assign pix_line = p4_dst_addr[ADDR_W-1:BLIT_LINE_LSB];
    assign pix_word = p4_dst_addr[BLIT_WORD_MSB:BLIT_WORD_LSB];
    assign pix_lane = p4_dst_addr[BLIT_BYTE_MSB:0];
    assign pix_byte = p4_dst_addr[BLIT_WORD_MSB:0];
    assign unused_addr_hi = ^p4_dst_addr[31:ADDR_W];

    assign line_hit = (pix_line == line_addr_q);
    assign busy     = (state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_WAIT);

    // A line miss stalls in the same cycle so upstream holds the pixel until the line reopens
    assign stall  = p4_write && (busy || ((state_q == ST_DIRTY) && !line_hit));
    assign accept = p4_write && !stall;

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[pix_word][{pix_lane, 3'b000} +: 8] <= p4_src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAN;
            line_addr_q <= '0;
            mask_q      <= '0;
            rptr_q      <= 4'd0;
            req_q       <= 1'b0;
        end else begin
            if (accept) begin
                mask_q[pix_byte] <= 1'b1;
            end
            case (state_q)
                ST_CLEAN: begin
                    if (accept) begin
                        line_addr_q <= pix_line;
                        state_q     <= ST_DIRTY;
                    end
                end
                ST_DIRTY: begin
                    // A same-line pixel arriving with flush is already merged above
                    if ((p4_write && !line_hit) || flush_req) begin
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (blitw_sdram_ack) begin
                        req_q   <= 1'b0;
                        rptr_q  <= 4'd0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (blitw_sdram_wready) begin
                        rptr_q <= rptr_q + 4'd1;
                        if (rptr_q == 4'(LINE_WORDS - 1)) begin
                            mask_q  <= '0;
                            state_q <= blitw_sdram_complete ? ST_CLEAN : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (blitw_sdram_complete) begin
                        state_q <= ST_CLEAN;
                    end
                end
                default: begin
                    state_q <= ST_CLEAN;
                end
            endcase
        end
    end

    assign idle              = (state_q == ST_CLEAN);
    assign blitw_sdram_req   = req_q;
    assign blitw_sdram_addr  = {line_addr_q, {BLIT_LINE_LSB{1'b0}}};
    assign blitw_sdram_wdata = data_q[rptr_q];
    assign blitw_sdram_wmask = (state_q == ST_DATA) ? mask_q[{rptr_q, 2'b00} +: 4] : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_blit_mem_write.sv
`default_nettype none
// tb_blit_mem_write: random pixel streams against a line-merging reference model with a randomized SDRAM responder.
module tb_blit_mem_write;

    logic        clk;
    logic        reset;
    logic        p4_write;
    logic [31:0] p4_dst_addr;
    logic [7:0]  p4_src_data;
    logic        flush_req;
    logic        idle;
    logic        stall;
    logic        req;
    logic [25:0] addr;
    logic        ack;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        complete;

    blit_mem_write #(.LINE_WORDS(16), .ADDR_W(26)) dut (
        .clk                 (clk),
        .reset               (reset),
        .p4_write            (p4_write),
        .p4_dst_addr         (p4_dst_addr),
        .p4_src_data         (p4_src_data),
        .flush_req           (flush_req),
        .idle                (idle),
        .stall               (stall),
        .blitw_sdram_req     (req),
        .blitw_sdram_addr    (addr),
        .blitw_sdram_ack     (ack),
        .blitw_sdram_wready  (wready),
        .blitw_sdram_wdata   (wdata),
        .blitw_sdram_wmask   (wmask),
        .blitw_sdram_complete(complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one open line of bytes; a burst is emitted on line change or flush
    typedef struct packed {
        logic [25:0]  baddr;
        logic [511:0] bdata;
        logic [63:0]  bmask;
    } burst_t;

    burst_t       exp_q[$];
    logic [511:0] m_data;
    logic [63:0]  m_mask;
    logic [19:0]  m_line;
    bit           m_valid;

    task automatic model_flush();
        burst_t b;
        if (m_valid) begin
            b.baddr = {m_line, 6'b0};
            b.bdata = m_data;
            b.bmask = m_mask;
            exp_q.push_back(b);
            m_valid = 1'b0;
            m_mask  = '0;
        end
    endtask

    task automatic model_pixel(input logic [31:0] a, input logic [7:0] d);
        int off;
        off = int'(a[5:0]);
        if (m_valid && (a[25:6] != m_line)) model_flush();
        if (!m_valid) begin
            m_valid = 1'b1;
            m_line  = a[25:6];
            m_mask  = '0;
        end
        m_data[off*8 +: 8] = d;
        m_mask[off] = 1'b1;
    endtask

    // SDRAM responder state
    int           rs = 0;
    int           dly = 0;
    int           beats = 0;
    bit           first_data = 1'b0;
    logic [25:0]  cap_addr;
    logic [511:0] cap_data;
    logic [63:0]  cap_mask;

    task automatic finish_burst();
        burst_t     e;
        logic [3:0] em;
        logic [31:0] bm;
        if (exp_q.size() == 0) begin
            check("burst_unexpected", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("burst_addr", 64'(cap_addr), 64'(e.baddr));
            check("burst_mask", cap_mask, e.bmask);
            for (int i = 0; i < 16; i++) begin
                em = e.bmask[i*4 +: 4];
                bm = {{8{em[3]}}, {8{em[2]}}, {8{em[1]}}, {8{em[0]}}};
                check($sformatf("beat%0d_data", i), 64'(cap_data[i*32 +: 32] & bm), 64'(e.bdata[i*32 +: 32] & bm));
            end
        end
    endtask

    initial begin
        ack = 1'b0;
        wready = 1'b0;
        complete = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            ack = 1'b0;
            wready = 1'b0;
            complete = 1'b0;
            if (reset) begin
                rs = 0;
            end else begin
                if (rs != 0 && p4_write) check("busy_stall", 64'(stall), 64'd1);
                case (rs)
                    0: if (req) begin
                        dly = int'($urandom_range(0, 5));
                        rs  = 1;
                    end
                    1: begin
                        check("req_hold", 64'(req), 64'd1);
                        if (dly == 0) begin
                            ack        = 1'b1;
                            cap_addr   = addr;
                            cap_data   = '0;
                            cap_mask   = '0;
                            beats      = 0;
                            first_data = 1'b1;
                            rs         = 2;
                        end else begin
                            dly--;
                        end
                    end
                    2: begin
                        if (first_data) begin
                            check("req_drop", 64'(req), 64'd0);
                            first_data = 1'b0;
                        end
                        if ($urandom_range(0, 1) == 1) begin
                            wready = 1'b1;
                            cap_data[beats*32 +: 32] = wdata;
                            cap_mask[beats*4 +: 4]   = wmask;
                            if (beats == 15) begin
                                if ($urandom_range(0, 1) == 1) begin
                                    complete = 1'b1;
                                    finish_burst();
                                    rs = 0;
                                end else begin
                                    dly = int'($urandom_range(0, 3));
                                    rs  = 3;
                                end
                            end
                            beats++;
                        end
                    end
                    3: begin
                        if (dly == 0) begin
                            complete = 1'b1;
                            finish_burst();
                            rs = 0;
                        end else begin
                            dly--;
                        end
                    end
                    default: rs = 0;
                endcase
            end
        end
    end

    task automatic send_pixel(input logic [31:0] a, input logic [7:0] d, input bit fl, output bit first_stall);
        bit hit_flush;
        int n;
        hit_flush = fl && m_valid && (a[25:6] == m_line);
        model_pixel(a, d);
        if (hit_flush) model_flush();
        @(negedge clk);
        p4_write    = 1'b1;
        p4_dst_addr = a;
        p4_src_data = d;
        flush_req   = hit_flush;
        #1;
        first_stall = stall;
        n = 0;
        while (stall && n < 400) begin
            @(negedge clk);
            flush_req = 1'b0;
            #1;
            n++;
        end
        if (n >= 400) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        p4_write  = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush_req = 1'b1;
        model_flush();
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(idle && exp_q.size() == 0 && rs == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 64'(n < 3000), 64'd1);
    endtask

    bit          st;
    logic [31:0] ra;
    logic [19:0] cur_line;
    int          n_poll;

    initial begin
        reset       = 1'b1;
        p4_write    = 1'b0;
        p4_dst_addr = '0;
        p4_src_data = '0;
        flush_req   = 1'b0;
        m_valid     = 1'b0;
        m_mask      = '0;
        m_data      = '0;
        m_line      = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        #1;
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_req", 64'(req), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_wmask", 64'(wmask), 64'd0);

        // Four adjacent bytes then flush
        send_pixel(32'h1000, 8'h11, 1'b0, st);
        send_pixel(32'h1001, 8'h22, 1'b0, st);
        send_pixel(32'h1002, 8'h33, 1'b0, st);
        send_pixel(32'h1003, 8'h44, 1'b0, st);
        do_flush();
        wait_idle();

        // Line miss evicts the open line and then opens the new one
        send_pixel(32'h1005, 8'h55, 1'b0, st);
        check("hit_no_stall", 64'(st), 64'd0);
        send_pixel(32'h1040, 8'h66, 1'b0, st);
        check("miss_stall", 64'(st), 64'd1);
        do_flush();
        wait_idle();

        // Same byte twice: last write wins
        send_pixel(32'h2003, 8'hAA, 1'b0, st);
        send_pixel(32'h2003, 8'hBB, 1'b0, st);
        do_flush();
        wait_idle();

        // Flush with nothing dirty is ignored
        do_flush();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("clean_flush_req", 64'(req), 64'd0);
            check("clean_flush_idle", 64'(idle), 64'd1);
        end

        // Random pixel stream over a few neighbouring lines
        cur_line = 20'h00080;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) cur_line = 20'h00080 + 20'($urandom_range(0, 3));
            ra = {6'($urandom_range(0, 63)), cur_line, 6'($urandom_range(0, 63))};
            send_pixel(ra, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), st);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) do_flush();
        end
        do_flush();
        wait_idle();

        // Reset in the middle of a burst abandons it
        send_pixel(32'h3000, 8'h77, 1'b0, st);
        do_flush();
        n_poll = 0;
        @(posedge clk);
        #2;
        while (!(rs == 2 && beats == 7) && n_poll < 500) begin
            @(posedge clk);
            #2;
            n_poll++;
        end
        check("reach_beat7", 64'(n_poll < 500), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_valid = 1'b0;
        m_mask  = '0;
        @(negedge clk);
        #1;
        check("midrst_req", 64'(req), 64'd0);
        check("midrst_idle", 64'(idle), 64'd1);
        send_pixel(32'h4010, 8'h99, 1'b0, st);
        check("post_rst_stall", 64'(st), 64'd0);
        do_flush();
        wait_idle();

        check("final_idle", 64'(idle), 64'd1);
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
